// File: rtl/fir_seq_mac.sv
// Time-multiplexed FIR: one signed multiply-accumulate per cycle over NUM_ELEM taps.
// Optional macro FIR_ROUND_EN selects round-half-up with positive saturation instead of floor truncation.
module fir_seq_mac #(
  parameter int BITS_PER_ELEM  = 8,
  parameter int NUM_ELEM       = 9,
  parameter int SUM_TRUNCATION = 8,
  parameter logic [NUM_ELEM*BITS_PER_ELEM-1:0] FILTER_VAL = '0,
  parameter int MAX_BITS       = 2*BITS_PER_ELEM + $clog2(NUM_ELEM),
  parameter int ADDR_BITS      = $clog2(NUM_ELEM)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_sample_valid,
  input  logic signed [BITS_PER_ELEM-1:0]  i_sample,
  output logic                             o_ready,
  input  logic                             i_coef_we,
  input  logic        [ADDR_BITS-1:0]      i_coef_addr,
  input  logic signed [BITS_PER_ELEM-1:0]  i_coef_data,
  output logic                             o_valid,
  output logic signed [SUM_TRUNCATION-1:0] o_wavelet,
  output logic                             o_busy
);

  localparam int PROD_BITS = 2*BITS_PER_ELEM;
  localparam int DROP_BITS = MAX_BITS - SUM_TRUNCATION;
  localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(NUM_ELEM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic signed [BITS_PER_ELEM-1:0]  taps  [NUM_ELEM];
  logic signed [BITS_PER_ELEM-1:0]  coefs [NUM_ELEM];
  logic signed [MAX_BITS-1:0]       acc;
  logic signed [MAX_BITS-1:0]       acc_next;
  logic signed [PROD_BITS-1:0]      prod;
  logic        [ADDR_BITS-1:0]      idx;
  logic signed [SUM_TRUNCATION-1:0] wavelet_next;

  logic accept;
  logic coef_wr;
  logic addr_ok;
  logic last_tap;

  assign addr_ok  = {{(32-ADDR_BITS){1'b0}}, i_coef_addr} < 32'(NUM_ELEM);
  assign accept   = (state == IDLE) && i_sample_valid;
  assign coef_wr  = (state == IDLE) && i_coef_we && addr_ok;
  assign last_tap = (state == CALC) && (idx == LAST_IDX);

  assign o_ready = (state == IDLE);
  assign o_busy  = (state != IDLE);
  assign o_valid = (state == DONE);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values; blocking here would make results depend on block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (i_sample_valid) state_next = CALC;
      CALC:    if (idx == LAST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multiply-accumulate; the product is full precision and sign-extended.
  // ---------------------------------------------------------------------------
  always_comb begin
    prod     = coefs[idx] * taps[idx];
    acc_next = acc + MAX_BITS'(prod);
  end

`ifdef FIR_ROUND_EN
  generate
    if (DROP_BITS > 0) begin : g_round
      localparam logic [MAX_BITS:0] HALF = (MAX_BITS+1)'(1) << (DROP_BITS - 1);
      logic [MAX_BITS:0]       rounded;
      logic [SUM_TRUNCATION:0] rounded_top;

      // One guard bit catches a carry past the positive range of o_wavelet.
      always_comb begin
        rounded     = {acc_next[MAX_BITS-1], acc_next} + HALF;
        rounded_top = rounded[MAX_BITS -: SUM_TRUNCATION+1];
        if (!rounded_top[SUM_TRUNCATION] && rounded_top[SUM_TRUNCATION-1])
          wavelet_next = {1'b0, {(SUM_TRUNCATION-1){1'b1}}};
        else
          wavelet_next = rounded_top[SUM_TRUNCATION-1:0];
      end
    end else begin : g_no_drop
      assign wavelet_next = acc_next;
    end
  endgenerate
`else
  assign wavelet_next = acc_next[MAX_BITS-1 -: SUM_TRUNCATION];
`endif

  // ---------------------------------------------------------------------------
  // Datapath registers. The result is captured on the last MAC edge so it is
  // already stable while o_valid is high in DONE.
  // ---------------------------------------------------------------------------
  // NOTE: the coefficient bank is flop-based and must come out of reset
  // holding FILTER_VAL, so it is reset like ordinary state rather than
  // being treated as an unreset RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_ELEM; k++) begin
        taps[k]  <= '0;
        coefs[k] <= FILTER_VAL[BITS_PER_ELEM*k +: BITS_PER_ELEM];
      end
      acc       <= '0;
      idx       <= '0;
      o_wavelet <= '0;
    end else begin
      if (coef_wr)
        coefs[i_coef_addr] <= i_coef_data;

      if (accept) begin
        for (int k = NUM_ELEM-1; k > 0; k--)
          taps[k] <= taps[k-1];
        taps[0] <= i_sample;
        acc     <= '0;
        idx     <= '0;
      end else if (state == CALC) begin
        acc <= acc_next;
        idx <= last_tap ? '0 : idx + 1'b1;
        if (last_tap)
          o_wavelet <= wavelet_next;
      end
    end
  end

endmodule

// File: tb/tb_fir_seq_mac.sv
// Self-checking bench for fir_seq_mac: vector table plus scoreboard-driven multi-cycle sequences.
module tb_fir_seq_mac;

  localparam int B  = 8;
  localparam int N  = 9;
  localparam int ST = 8;
  localparam int AB = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_sample_valid;
  logic signed [B-1:0]  i_sample;
  logic                 o_ready;
  logic                 i_coef_we;
  logic [AB-1:0]        i_coef_addr;
  logic signed [B-1:0]  i_coef_data;
  logic                 o_valid;
  logic signed [ST-1:0] o_wavelet;
  logic                 o_busy;

  fir_seq_mac dut (
    .clk            (clk),
    .rst            (rst),
    .i_sample_valid (i_sample_valid),
    .i_sample       (i_sample),
    .o_ready        (o_ready),
    .i_coef_we      (i_coef_we),
    .i_coef_addr    (i_coef_addr),
    .i_coef_data    (i_coef_data),
    .o_valid        (o_valid),
    .o_wavelet      (o_wavelet),
    .o_busy         (o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int wavelet;
    int due;
  } exp_t;

  typedef struct {
    logic signed [B-1:0] coef;
    logic signed [B-1:0] sample;
    int                  exp_floor;
    int                  exp_round;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic int sel(input int f, input int r);
`ifdef FIR_ROUND_EN
    return r;
`else
    return f;
`endif
  endfunction

  // Result strobe sits in the cycle closed by edge accept+NUM_ELEM+1,
  // i.e. it is visible at the negedge where cyc == accept count + N.
  always @(negedge clk) begin
    if (!rst && o_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("wavelet", int'(o_wavelet), mon_e.wavelet);
        check("latency", cyc, mon_e.due);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_wavelet", int'(o_wavelet), 0);
    check("rst_async_valid", int'(o_valid), 0);
    check("rst_async_ready", int'(o_ready), 1);
    check("rst_async_busy", int'(o_busy), 0);
    sb.delete();
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic write_coef(input int addr, input logic signed [B-1:0] data);
    @(negedge clk);
    i_coef_we   = 1'b1;
    i_coef_addr = AB'(addr);
    i_coef_data = data;
    @(posedge clk);
    #1 i_coef_we = 1'b0;
  endtask

  task automatic push_sample(input logic signed [B-1:0] s, input int exp_w, input bit expect_out);
    bit ready_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (o_ready) begin
        ready_seen = 1'b1;
        break;
      end
    end
    if (!ready_seen) begin
      check("ready_timeout", 0, 1);
      return;
    end
    i_sample_valid = 1'b1;
    i_sample       = s;
    @(posedge clk);
    #1;
    if (expect_out) sb.push_back('{exp_w, cyc + N});
    i_sample_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_ready && sb.size() == 0) return;
    end
    check("idle_timeout", 0, 1);
  endtask

  vec_t vecs [8];
  int   lows;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'sh40,    8'sd127,    1,  2};
    vecs[1] = '{8'sd127,  -8'sd128,   -4, -4};
    vecs[2] = '{8'sd127,   8'sd127,    3,  4};
    vecs[3] = '{-8'sd128,  8'sd127,   -4, -4};
    vecs[4] = '{-8'sd128, -8'sd128,    4,  4};
    vecs[5] = '{8'sd1,     8'sd1,      0,  0};
    vecs[6] = '{-8'sd1,    8'sd1,     -1,  0};
    vecs[7] = '{8'sh40,    8'sd64,     1,  1};

    rst            = 1'b1;
    i_sample_valid = 1'b0;
    i_sample       = '0;
    i_coef_we      = 1'b0;
    i_coef_addr    = '0;
    i_coef_data    = '0;

    do_reset();
    check("reset_ready", int'(o_ready), 1);
    check("reset_valid", int'(o_valid), 0);

    // Single-tap vectors: only coef[0] is non-zero, so only the newest sample matters.
    for (int v = 0; v < 8; v++) begin
      write_coef(0, vecs[v].coef);
      push_sample(vecs[v].sample, sel(vecs[v].exp_floor, vecs[v].exp_round), 1'b1);
      wait_idle();
    end

    // Delay line: coef[2] picks the sample pushed two acceptances earlier.
    do_reset();
    write_coef(2, 8'sh40);
    push_sample(8'sd100, 0, 1'b1);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_ready) break;
      lows++;
    end
    check("ready_low_cycles", lows, 10);
    push_sample(8'sd0, 0, 1'b1);
    push_sample(8'sd0, sel(1, 2), 1'b1);
    wait_idle();

    // Full scale: partial sums grow by 16384 per filled tap.
    do_reset();
    for (int k = 0; k < N; k++) write_coef(k, -8'sd128);
    for (int k = 1; k <= N; k++) push_sample(-8'sd128, 4*k, 1'b1);
    wait_idle();

    // Protocol: sample and coefficient write offered during CALC are dropped.
    do_reset();
    write_coef(0, 8'sh40);
    write_coef(1, 8'sh40);
    push_sample(8'sd127, sel(1, 2), 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("calc_busy", int'(o_busy), 1);
    check("calc_ready", int'(o_ready), 0);
    i_sample_valid = 1'b1;
    i_sample       = -8'sd128;
    i_coef_we      = 1'b1;
    i_coef_addr    = 4'd1;
    i_coef_data    = 8'sd0;
    @(posedge clk);
    #1;
    i_sample_valid = 1'b0;
    i_coef_we      = 1'b0;
    wait_idle();
    push_sample(8'sd0, sel(1, 2), 1'b1);
    wait_idle();

    // Out-of-range addresses must not alias onto real taps.
    write_coef(9, -8'sd128);
    write_coef(15, -8'sd128);
    // Write and acceptance in the same IDLE cycle: new coef[0] is used at once.
    @(negedge clk);
    i_coef_we      = 1'b1;
    i_coef_addr    = 4'd0;
    i_coef_data    = 8'sd127;
    i_sample_valid = 1'b1;
    i_sample       = 8'sd127;
    @(posedge clk);
    #1;
    sb.push_back('{sel(3, 4), cyc + N});
    i_coef_we      = 1'b0;
    i_sample_valid = 1'b0;
    wait_idle();
    push_sample(8'sd0, sel(1, 2), 1'b1);
    wait_idle();

    // Reset during CALC aborts the result; the next sample computes normally.
    do_reset();
    write_coef(0, 8'sh40);
    push_sample(8'sd127, 0, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", int'(o_busy), 0);
    check("abort_ready", int'(o_ready), 1);
    check("abort_valid", int'(o_valid), 0);
    sb.delete();
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (15) @(negedge clk);
    check("abort_idle", int'(o_ready), 1);
    write_coef(0, 8'sh40);
    push_sample(8'sd127, sel(1, 2), 1'b1);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
